mem_access_unit: RTL and testbench

Memory-access stage of the Riviera pipeline, sitting between EX and WB. Takes the effective address and store data computed by the EX ALU and performs the data-memory transaction over a request/grant/response handshake. Handles byte/half/word/double alignment, byte-enable generation, load extraction and sign/zero extension, and stalls the pipeline while a transaction is outstanding. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_unit.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: sits between EX and WB, performs the data-memory
// transaction for loads/stores and passes everything else through with one
// cycle of latency.
//
// Handshake summary:
//   * dmem_req/dmem_we/dmem_addr/dmem_be/dmem_wdata are held stable from the
//     cycle the request is raised until the cycle dmem_gnt is sampled high.
//   * A load response (dmem_rvalid/dmem_rdata) is only accepted in WAIT_R,
//     i.e. strictly after the grant cycle; rvalid seen anywhere else is dropped.
//   * Upstream holds i_struct stable while o_stall is high; o_valid pulses for
//     exactly one cycle per completed instruction.

package mem_access_unit_pkg;

    typedef struct packed {
        logic        is_valid;
        logic        mem_rd;
        logic        mem_wr;
        logic        rf_wr;
        logic [4:0]  rd_idx;
        logic [63:0] mem_addr;
        logic [63:0] mem_data;
        logic [63:0] rf_wr_data;
    } interconnection_struct;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } mau_state_t;

endpackage

module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  interconnection_struct i_struct,
    input  logic [1:0]           i_mem_size,
    input  logic                 i_mem_unsigned,
    output interconnection_struct o_struct,
    output logic                 o_valid,
    output logic                 o_stall,
    output logic                 o_misaligned,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [63:0]          dmem_addr,
    output logic [7:0]           dmem_be,
    output logic [63:0]          dmem_wdata,
    input  logic                 dmem_gnt,
    input  logic                 dmem_rvalid,
    input  logic [63:0]          dmem_rdata,
    output logic [1:0]           o_dbg_state
);

    mau_state_t           r_state;
    interconnection_struct r_ins;
    interconnection_struct r_out;
    logic [2:0]           r_lane;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic                 r_valid;
    logic                 r_misaligned;
    logic                 r_dmem_req;
    logic                 r_dmem_we;
    logic [63:0]          r_dmem_addr;
    logic [7:0]           r_dmem_be;
    logic [63:0]          r_dmem_wdata;

    logic [2:0]           w_a;
    logic                 w_is_mem;
    logic                 w_aligned;
    logic                 w_accept;
    logic [7:0]           w_be;
    logic [63:0]          w_wdata;
    logic [63:0]          w_lane_data;
    logic [63:0]          w_load;
    interconnection_struct w_mis_struct;
    interconnection_struct w_load_struct;

    // Decode of the incoming instruction: alignment, lane enables, store data.
    always_comb begin
        w_a       = i_struct.mem_addr[2:0];
        w_is_mem  = i_struct.is_valid && (i_struct.mem_rd || i_struct.mem_wr);
        w_aligned = 1'b1;
        w_be      = 8'hFF;
        case (i_mem_size)
            2'd0: begin
                w_aligned = 1'b1;
                w_be      = 8'h01 << w_a;
            end
            2'd1: begin
                w_aligned = (w_a[0] == 1'b0);
                w_be      = 8'h03 << w_a;
            end
            2'd2: begin
                w_aligned = (w_a[1:0] == 2'b00);
                w_be      = 8'h0F << w_a;
            end
            default: begin
                w_aligned = (w_a == 3'b000);
                w_be      = 8'hFF;
            end
        endcase
        w_wdata  = i_struct.mem_data << {w_a, 3'b000};
        w_accept = (r_state == ST_IDLE) && w_is_mem && w_aligned;

        w_mis_struct            = i_struct;
        w_mis_struct.rf_wr_data = 64'd0;
    end

    // Load extraction: shift the addressed lane down, then zero/sign extend.
    always_comb begin
        w_lane_data = dmem_rdata >> {r_lane, 3'b000};
        w_load      = w_lane_data;
        case (r_size)
            2'd0: w_load = r_unsigned ? {56'd0, w_lane_data[7:0]}
                                      : {{56{w_lane_data[7]}}, w_lane_data[7:0]};
            2'd1: w_load = r_unsigned ? {48'd0, w_lane_data[15:0]}
                                      : {{48{w_lane_data[15]}}, w_lane_data[15:0]};
            2'd2: w_load = r_unsigned ? {32'd0, w_lane_data[31:0]}
                                      : {{32{w_lane_data[31]}}, w_lane_data[31:0]};
            default: w_load = dmem_rdata;
        endcase
        w_load_struct            = r_ins;
        w_load_struct.rf_wr_data = w_load;
    end

    // Stage FSM with registered outputs: IDLE accepts, REQ waits for grant,
    // WAIT_R waits for load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ins        <= '0;
            r_out        <= '0;
            r_lane       <= 3'd0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= 64'd0;
            r_dmem_be    <= 8'd0;
            r_dmem_wdata <= 64'd0;
        end else begin
            r_valid      <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_struct.is_valid) begin
                        if (!w_is_mem) begin
                            r_out   <= i_struct;
                            r_valid <= 1'b1;
                        end else if (!w_aligned) begin
                            r_out        <= w_mis_struct;
                            r_valid      <= 1'b1;
                            r_misaligned <= 1'b1;
                        end else begin
                            r_ins        <= i_struct;
                            r_lane       <= w_a;
                            r_size       <= i_mem_size;
                            r_unsigned   <= i_mem_unsigned;
                            r_dmem_req   <= 1'b1;
                            // A store takes precedence if both flags are set.
                            r_dmem_we    <= i_struct.mem_wr;
                            r_dmem_addr  <= {i_struct.mem_addr[63:3], 3'b000};
                            r_dmem_be    <= w_be;
                            r_dmem_wdata <= w_wdata;
                            r_state      <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        r_dmem_req <= 1'b0;
                        if (r_dmem_we) begin
                            r_out   <= r_ins;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT_R;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (dmem_rvalid) begin
                        r_out   <= w_load_struct;
                        r_valid <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_struct     = r_out;
    assign o_valid      = r_valid;
    assign o_misaligned = r_misaligned;
    assign o_stall      = (r_state != ST_IDLE) || w_accept;
    assign dmem_req     = r_dmem_req;
    assign dmem_we      = r_dmem_we;
    assign dmem_addr    = r_dmem_addr;
    assign dmem_be      = r_dmem_be;
    assign dmem_wdata   = r_dmem_wdata;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios followed by randomized
// loads/stores/pass-through ops, checked against a byte-level model.

module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic                  clk;
    logic                  rst;
    interconnection_struct i_struct;
    logic [1:0]            i_mem_size;
    logic                  i_mem_unsigned;
    interconnection_struct o_struct;
    logic                  o_valid;
    logic                  o_stall;
    logic                  o_misaligned;
    logic                  dmem_req;
    logic                  dmem_we;
    logic [63:0]           dmem_addr;
    logic [7:0]            dmem_be;
    logic [63:0]           dmem_wdata;
    logic                  dmem_gnt;
    logic                  dmem_rvalid;
    logic [63:0]           dmem_rdata;
    logic [1:0]            o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk            (clk),
        .rst            (rst),
        .i_struct       (i_struct),
        .i_mem_size     (i_mem_size),
        .i_mem_unsigned (i_mem_unsigned),
        .o_struct       (o_struct),
        .o_valid        (o_valid),
        .o_stall        (o_stall),
        .o_misaligned   (o_misaligned),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_gnt       (dmem_gnt),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .o_dbg_state    (o_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-level) ----------------
    function automatic bit m_aligned(input logic [63:0] addr, input logic [1:0] size);
        int n = 1 << size;
        return (addr % n) == 0;
    endfunction

    function automatic logic [7:0] m_be(input logic [1:0] size, input logic [2:0] a);
        int n = 1 << size;
        logic [7:0] be = 8'd0;
        for (int i = 0; i < 8; i++)
            if (i >= a && i < a + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] data, input logic [2:0] a);
        logic [63:0] r = 64'd0;
        for (int i = 0; i < 8; i++)
            if (i >= a) r[8*i +: 8] = data[8*(i-a) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [1:0] size,
                                           input logic [2:0] a, input logic uns);
        int n = 1 << size;
        logic [63:0] v = 64'd0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(a+k) +: 8];
        if (!uns && n < 8 && v[8*n-1])
            for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        i_struct       = '0;
        i_mem_size     = 2'd0;
        i_mem_unsigned = 1'b0;
    endtask

    task automatic pass_op(input string tag, input logic [63:0] rfd);
        @(negedge clk);
        i_struct            = '0;
        i_struct.is_valid   = 1'b1;
        i_struct.rf_wr      = 1'b1;
        i_struct.rd_idx     = 5'($urandom_range(0, 31));
        i_struct.rf_wr_data = rfd;
        #1;
        check({tag, "_stall"}, o_stall, 1'b0);
        @(negedge clk);
        check({tag, "_valid"}, o_valid, 1'b1);
        check({tag, "_rf"}, o_struct.rf_wr_data, rfd);
        check({tag, "_req"}, dmem_req, 1'b0);
        drive_idle();
        @(negedge clk);
        check({tag, "_valid_drop"}, o_valid, 1'b0);
        check({tag, "_req2"}, dmem_req, 1'b0);
    endtask

    // One memory instruction with configurable grant / response delays.
    // gnt_dly: extra REQ cycles before grant; rv_dly: cycles after grant until rvalid (>=1).
    task automatic mem_op(input string tag, input logic is_wr, input logic [63:0] addr,
                          input logic [63:0] data, input logic [1:0] size, input logic uns,
                          input int gnt_dly, input int rv_dly, input logic [63:0] rdata,
                          input logic rv_with_gnt, output logic [63:0] obs_rf,
                          output logic [7:0] obs_be, output logic [63:0] obs_wdata,
                          output int req_cycles);
        logic [2:0]  a   = addr[2:0];
        bit          al  = m_aligned(addr, size);
        logic [63:0] rfd = {32'hC0DE_0000, $urandom};
        obs_rf = 64'hX; obs_be = 8'h0; obs_wdata = 64'h0; req_cycles = 0;
        @(negedge clk);
        i_struct            = '0;
        i_struct.is_valid   = 1'b1;
        i_struct.mem_rd     = !is_wr;
        i_struct.mem_wr     = is_wr;
        i_struct.rf_wr      = !is_wr;
        i_struct.rd_idx     = 5'($urandom_range(0, 31));
        i_struct.mem_addr   = addr;
        i_struct.mem_data   = data;
        i_struct.rf_wr_data = rfd;
        i_mem_size          = size;
        i_mem_unsigned      = uns;
        dmem_gnt            = 1'b0;
        dmem_rvalid         = 1'b0;
        #1;
        check({tag, "_stall_accept"}, o_stall, al);
        @(negedge clk);
        if (!al) begin
            check({tag, "_mis"}, o_misaligned, 1'b1);
            check({tag, "_mis_valid"}, o_valid, 1'b1);
            check({tag, "_mis_rf"}, o_struct.rf_wr_data, 64'd0);
            check({tag, "_mis_req"}, dmem_req, 1'b0);
            obs_rf = o_struct.rf_wr_data;
            drive_idle();
            @(negedge clk);
            check({tag, "_mis_drop"}, o_misaligned, 1'b0);
            check({tag, "_mis_valid_drop"}, o_valid, 1'b0);
            check({tag, "_mis_req2"}, dmem_req, 1'b0);
            return;
        end
        obs_be    = dmem_be;
        obs_wdata = dmem_wdata;
        check({tag, "_addr"}, dmem_addr, addr & ~64'd7);
        check({tag, "_we"}, dmem_we, is_wr);
        check({tag, "_be"}, dmem_be, m_be(size, a));
        if (is_wr) check({tag, "_wdata"}, dmem_wdata, m_wdata(data, a));
        for (int k = 0; k <= gnt_dly; k++) begin
            if (dmem_req) req_cycles++;
            check({tag, "_req_stall"}, o_stall, 1'b1);
            check({tag, "_req_noval"}, o_valid, 1'b0);
            check({tag, "_addr_hold"}, dmem_addr, addr & ~64'd7);
            if (k == gnt_dly) begin
                dmem_gnt = 1'b1;
                if (rv_with_gnt) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = ~rdata;
                end
            end
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
        end
        check({tag, "_req_drop"}, dmem_req, 1'b0);
        if (is_wr) begin
            check({tag, "_st_valid"}, o_valid, 1'b1);
            check({tag, "_st_rf"}, o_struct.rf_wr_data, rfd);
            obs_rf = o_struct.rf_wr_data;
            drive_idle();
            @(negedge clk);
            check({tag, "_st_valid_drop"}, o_valid, 1'b0);
        end else begin
            for (int j = 1; j <= rv_dly; j++) begin
                check({tag, "_wr_stall"}, o_stall, 1'b1);
                check({tag, "_wr_noval"}, o_valid, 1'b0);
                if (j == rv_dly) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end
                @(negedge clk);
                dmem_rvalid = 1'b0;
            end
            check({tag, "_ld_valid"}, o_valid, 1'b1);
            check({tag, "_ld_rf"}, o_struct.rf_wr_data, m_load(rdata, size, a, uns));
            obs_rf = o_struct.rf_wr_data;
            drive_idle();
            #1;
            check({tag, "_ld_stall_drop"}, o_stall, 1'b0);
            @(negedge clk);
            check({tag, "_ld_valid_drop"}, o_valid, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, o_valid, 1'b0);
        check({tag, "_stall"}, o_stall, 1'b0);
        check({tag, "_mis"}, o_misaligned, 1'b0);
        check({tag, "_req"}, dmem_req, 1'b0);
        check({tag, "_we"}, dmem_we, 1'b0);
        check({tag, "_addr"}, dmem_addr, 64'd0);
        check({tag, "_be"}, dmem_be, 8'd0);
        check({tag, "_wdata"}, dmem_wdata, 64'd0);
        check({tag, "_ostruct"}, o_struct.rf_wr_data, 64'd0);
        check({tag, "_state"}, o_dbg_state, 2'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [63:0] rf, wd;
        logic [7:0]  be;
        int          rc;
        drive_idle();
        rst         = 1'b1;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 64'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_novalid", o_valid, 1'b0);

        pass_op("pass", 64'h1234);

        mem_op("sb", 1'b1, 64'h1003, 64'hAB, 2'd0, 1'b0, 2, 1, 64'd0, 1'b0, rf, be, wd, rc);
        check("sb_be_const", be, 8'h08);
        check("sb_wdata_const", wd, 64'hAB00_0000);
        check("sb_req_cycles", rc, 3);

        mem_op("lh_s", 1'b0, 64'h2006, 64'd0, 2'd1, 1'b0, 0, 1, 64'h8001_0000_0000_0000,
               1'b0, rf, be, wd, rc);
        check("lh_s_const", rf, 64'hFFFF_FFFF_FFFF_8001);
        mem_op("lh_u", 1'b0, 64'h2006, 64'd0, 2'd1, 1'b1, 1, 2, 64'h8001_0000_0000_0000,
               1'b1, rf, be, wd, rc);
        check("lh_u_const", rf, 64'h8001);

        mem_op("lw_mis", 1'b0, 64'h3002, 64'd0, 2'd2, 1'b0, 0, 1, 64'd0, 1'b0, rf, be, wd, rc);

        mem_op("ld", 1'b0, 64'h4000, 64'd0, 2'd3, 1'b0, 0, 4, 64'h0123_4567_89AB_CDEF,
               1'b0, rf, be, wd, rc);
        check("ld_const", rf, 64'h0123_4567_89AB_CDEF);

        // Reset while waiting for load data; the late response must be dropped.
        @(negedge clk);
        i_struct          = '0;
        i_struct.is_valid = 1'b1;
        i_struct.mem_rd   = 1'b1;
        i_struct.mem_addr = 64'h5000;
        i_mem_size        = 2'd3;
        @(negedge clk);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        check("rst_mid_state", o_dbg_state, 2'd2);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check_reset_outputs("rst_late_rv");
        @(negedge clk);
        check("rst_late_valid", o_valid, 1'b0);

        // Randomized mix of pass-through, loads and stores.
        for (int t = 0; t < 60; t++) begin
            int          kind = $urandom_range(0, 9);
            logic [1:0]  sz   = 2'($urandom_range(0, 3));
            logic [63:0] ad   = {$urandom, $urandom};
            if (kind < 2) begin
                pass_op("rnd_pass", {$urandom, $urandom});
            end else begin
                if ($urandom_range(0, 4) != 0) ad = ad & ~((64'd1 << sz) - 64'd1);
                mem_op("rnd_mem", kind >= 6, ad, {$urandom, $urandom}, sz,
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 3),
                       {$urandom, $urandom}, 1'($urandom_range(0, 1)), rf, be, wd, rc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
